replay_seq: RTL and testbench

REPLAY_SEQ -- requirements
Module: replay_seq

---
 rtl/replay_pkg.sv | 15 +
 rtl/replay_watchdog.sv | 28 ++
 rtl/replay_seq.sv | 135 +++++++++++++
 tb/tb_replay_seq.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/replay_pkg.sv
// Shared types and constants for the replay sequencer: FSM state encoding,
// exit-code width and the code reported when the watchdog ends a run.
package replay_pkg;

    localparam int EXITCODE_W = 32;
    localparam logic [EXITCODE_W-1:0] TIMEOUT_CODE = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        RESET_HOLD = 2'd0,
        RUN        = 2'd1,
        DONE_PASS  = 2'd2,
        DONE_FAIL  = 2'd3
    } state_t;

endpackage

// File: rtl/replay_watchdog.sv
// Idle watchdog: counts consecutive enabled cycles and fires on the LIMIT-th
// one. An asserted clear (accepted tick) always wins over firing.
module replay_watchdog #(
    parameter int LIMIT = 1000000
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic count_en,
    output logic fire
);

    localparam int CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] r_idle;

    assign fire = count_en & ~clear & (r_idle == LAST);

    always_ff @(posedge clk) begin
        if (srst || clear) begin
            r_idle <= '0;
        end else if (count_en && !fire) begin
            r_idle <= r_idle + 1'b1;
        end
    end

endmodule

// File: rtl/replay_seq.sv
// Replay sequencer: holds the replayed design in reset, then advances it one
// cycle per host tick until the host reports an exit code.
// Optional idle watchdog enabled by defining REPLAY_WATCHDOG_EN.
module replay_seq
    import replay_pkg::*;
#(
    parameter int RESET_CYCLES   = 5,
    parameter int CYCLE_W        = 64,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  tick_valid,
    input  logic                  tick_exit,
    input  logic [EXITCODE_W-1:0] tick_exitcode,
    output logic                  tick_ready,
    output logic                  dut_reset,
    output logic                  run_en,
    output logic [CYCLE_W-1:0]    cycle_count,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic [EXITCODE_W-1:0] exitcode,
    output logic                  timeout
);

    localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

    state_t                  r_state;
    state_t                  w_state_next;
    logic [HOLD_W-1:0]       r_hold_cnt;
    logic [CYCLE_W-1:0]      r_cycle_count;
    logic [EXITCODE_W-1:0]   r_exitcode;
    logic                    w_accept;
    logic                    w_exit;
    logic                    w_fire;

    assign w_accept = tick_valid & tick_ready;
    assign w_exit   = w_accept & tick_exit;
    assign run_en   = w_accept & ~tick_exit;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= RESET_HOLD;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RESET_HOLD: if (r_hold_cnt == HOLD_LAST) w_state_next = RUN;
            RUN: begin
                if (w_exit) begin
                    w_state_next = (tick_exitcode == '0) ? DONE_PASS : DONE_FAIL;
                end else if (w_fire) begin
                    w_state_next = DONE_FAIL;
                end
            end
            default: w_state_next = r_state;
        endcase
    end

    // tick_ready is masked by reset so a tick coinciding with reset never lands.
    always_comb begin
        tick_ready = 1'b0;
        dut_reset  = 1'b0;
        done       = 1'b0;
        pass       = 1'b0;
        fail       = 1'b0;
        case (r_state)
            RESET_HOLD: dut_reset  = 1'b1;
            RUN:        tick_ready = ~reset;
            DONE_PASS:  begin done = 1'b1; pass = 1'b1; end
            DONE_FAIL:  begin done = 1'b1; fail = 1'b1; end
            default:    dut_reset  = 1'b1;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hold_cnt    <= '0;
            r_cycle_count <= '0;
            r_exitcode    <= '0;
        end else begin
            if (r_state == RESET_HOLD && r_hold_cnt != HOLD_LAST) begin
                r_hold_cnt <= r_hold_cnt + 1'b1;
            end
            if (run_en && r_cycle_count != {CYCLE_W{1'b1}}) begin
                r_cycle_count <= r_cycle_count + 1'b1;
            end
            if (w_exit) begin
                r_exitcode <= tick_exitcode;
            end else if (w_fire) begin
                r_exitcode <= TIMEOUT_CODE;
            end
        end
    end

    assign cycle_count = r_cycle_count;
    assign exitcode    = r_exitcode;

`ifdef REPLAY_WATCHDOG_EN
    logic r_timeout;

    replay_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clock),
        .srst     (reset),
        .clear    (w_accept),
        .count_en (r_state == RUN),
        .fire     (w_fire)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_timeout <= 1'b0;
        end else if (w_fire) begin
            r_timeout <= 1'b1;
        end
    end

    assign timeout = r_timeout;
`else
    logic w_unused_cfg;

    assign w_unused_cfg = (TIMEOUT_CYCLES > 0);
    assign w_fire       = 1'b0;
    assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_replay_seq.sv
// Self-checking bench for replay_seq: directed vector table, hand-written
// corner sequences and randomized ticks checked against a behavioural model.
module tb_replay_seq;

    localparam int RC = 5;
    localparam int TO = 20;
`ifdef REPLAY_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        tick_valid = 1'b0;
    logic        tick_exit = 1'b0;
    logic [31:0] tick_exitcode = '0;

    logic        d_ready, d_dres, d_run, d_done, d_pass, d_fail, d_to;
    logic [63:0] d_cnt;
    logic [31:0] d_code;
    logic        s_ready, s_dres, s_run, s_done, s_pass, s_fail, s_to;
    logic [3:0]  s_cnt;
    logic [31:0] s_code;

    always #5 clock = ~clock;

    replay_seq #(.RESET_CYCLES(RC), .CYCLE_W(64), .TIMEOUT_CYCLES(TO)) u_dut (
        .clock(clock), .reset(reset), .tick_valid(tick_valid), .tick_exit(tick_exit),
        .tick_exitcode(tick_exitcode), .tick_ready(d_ready), .dut_reset(d_dres),
        .run_en(d_run), .cycle_count(d_cnt), .done(d_done), .pass(d_pass),
        .fail(d_fail), .exitcode(d_code), .timeout(d_to)
    );

    replay_seq #(.RESET_CYCLES(RC), .CYCLE_W(4), .TIMEOUT_CYCLES(TO)) u_sat (
        .clock(clock), .reset(reset), .tick_valid(tick_valid), .tick_exit(tick_exit),
        .tick_exitcode(tick_exitcode), .tick_ready(s_ready), .dut_reset(s_dres),
        .run_en(s_run), .cycle_count(s_cnt), .done(s_done), .pass(s_pass),
        .fail(s_fail), .exitcode(s_code), .timeout(s_to)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: cycles since reset release, run outcome, tick count.
    int              m_since;
    bit              m_done;
    bit              m_pass;
    longint unsigned m_ticks;
    logic [31:0]     m_code;
    int              m_idle;
    bit              m_to;

    typedef struct {
        bit          rst, v, ex;
        logic [31:0] code;
        bit          e_dres, e_rdy, e_run;
        logic [63:0] e_cnt;
        bit          e_done, e_pass, e_fail;
        logic [31:0] e_code;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_since = 0; m_done = 0; m_pass = 0; m_ticks = 0;
        m_code = '0; m_idle = 0; m_to = 0;
    endtask

    task automatic check_outputs();
        bit hold, run, rdy, ren;
        longint unsigned sat;
        hold = (m_since < RC);
        run  = !hold && !m_done;
        rdy  = run && !reset;
        ren  = rdy && tick_valid && !tick_exit;
        sat  = (m_ticks > 15) ? 15 : m_ticks;
        chk("tick_ready", 64'(d_ready), 64'(rdy));
        chk("dut_reset", 64'(d_dres), 64'(hold));
        chk("run_en", 64'(d_run), 64'(ren));
        chk("cycle_count", d_cnt, m_ticks);
        chk("done", 64'(d_done), 64'(m_done));
        chk("pass", 64'(d_pass), 64'(m_done && m_pass));
        chk("fail", 64'(d_fail), 64'(m_done && !m_pass));
        chk("exitcode", 64'(d_code), 64'(m_code));
        chk("timeout", 64'(d_to), 64'(m_to));
        chk("sat_cycle_count", 64'(s_cnt), sat);
        chk("sat_done", 64'(s_done), 64'(m_done));
    endtask

    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else if (m_since < RC) begin
            m_since++;
        end else if (!m_done) begin
            if (tick_valid) begin
                m_idle = 0;
                if (tick_exit) begin
                    m_done = 1; m_pass = (tick_exitcode == 0); m_code = tick_exitcode;
                end else begin
                    m_ticks++;
                end
            end else begin
                m_idle++;
                if (WD && m_idle == TO) begin
                    m_done = 1; m_pass = 0; m_code = 32'hFFFF_FFFF; m_to = 1;
                end
            end
        end
    endtask

    task automatic drive_sample(input bit rst, input bit v, input bit ex, input logic [31:0] code);
        reset = rst; tick_valid = v; tick_exit = ex; tick_exitcode = code;
        @(negedge clock);
        check_outputs();
    endtask

    task automatic advance();
        model_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic step(input bit rst, input bit v, input bit ex, input logic [31:0] code);
        drive_sample(rst, v, ex, code);
        advance();
    endtask

    task automatic restart();
        step(1, 0, 0, 0);
        repeat (RC) step(0, 0, 0, 0);
    endtask

    function automatic vec_t mk(bit rst, bit v, bit ex, logic [31:0] code, bit dres, bit rdy,
                                bit run, logic [63:0] cnt, bit dn, bit ps, bit fl, logic [31:0] ec);
        vec_t t;
        t = '{rst, v, ex, code, dres, rdy, run, cnt, dn, ps, fl, ec};
        return t;
    endfunction

    initial begin
        int pv;
        bit rv;
        logic [31:0] rc;

        // Hold phase (ticks ignored), 10 advancing ticks, exit 0, sticky pass.
        for (int i = 0; i < RC; i++) tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 1, 0, 0, 0, 1, 1, 64'(i), 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 1, 0, 10, 0, 0, 0, 0));
        for (int i = 0; i < 2; i++) tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 10, 1, 1, 0, 0));

        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        model_reset();

        foreach (tbl[i]) begin
            drive_sample(tbl[i].rst, tbl[i].v, tbl[i].ex, tbl[i].code);
            chk("tbl_dut_reset", 64'(d_dres), 64'(tbl[i].e_dres));
            chk("tbl_tick_ready", 64'(d_ready), 64'(tbl[i].e_rdy));
            chk("tbl_run_en", 64'(d_run), 64'(tbl[i].e_run));
            chk("tbl_cycle_count", d_cnt, tbl[i].e_cnt);
            chk("tbl_done", 64'(d_done), 64'(tbl[i].e_done));
            chk("tbl_pass", 64'(d_pass), 64'(tbl[i].e_pass));
            chk("tbl_fail", 64'(d_fail), 64'(tbl[i].e_fail));
            chk("tbl_exitcode", 64'(d_code), 64'(tbl[i].e_code));
            advance();
        end

        // Three ticks then exit code 7; later ticks must not disturb the result.
        restart();
        repeat (3) step(0, 1, 0, 0);
        step(0, 1, 1, 32'd7);
        repeat (3) step(0, 1, 0, 0);
        step(0, 1, 1, 32'd0);
        chk("exit7_fail", 64'(d_fail), 1);
        chk("exit7_pass", 64'(d_pass), 0);
        chk("exit7_code", 64'(d_code), 7);
        chk("exit7_count", d_cnt, 3);

        // Reset arriving together with an exit tick discards the tick.
        restart();
        repeat (4) step(0, 1, 0, 0);
        step(1, 1, 1, 32'h5);
        chk("rst_exit_dut_reset", 64'(d_dres), 1);
        chk("rst_exit_done", 64'(d_done), 0);
        chk("rst_exit_code", 64'(d_code), 0);
        chk("rst_exit_count", d_cnt, 0);
        chk("rst_exit_ready", 64'(d_ready), 0);

        // Narrow counter saturates at 15.
        restart();
        repeat (20) step(0, 1, 0, 0);
        chk("sat_at_15", 64'(s_cnt), 15);
        chk("wide_at_20", d_cnt, 20);

        // Idle RUN behaviour with and without the watchdog.
        restart();
`ifdef REPLAY_WATCHDOG_EN
        repeat (TO - 1) step(0, 0, 0, 0);
        chk("wd_not_yet", 64'(d_done), 0);
        step(0, 0, 0, 0);
        chk("wd_fail", 64'(d_fail), 1);
        chk("wd_timeout", 64'(d_to), 1);
        chk("wd_code", 64'(d_code), 64'h0000_0000_FFFF_FFFF);
        restart();
        repeat (TO - 2) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        repeat (TO - 1) step(0, 0, 0, 0);
        chk("wd_restart_done", 64'(d_done), 0);
        step(0, 0, 0, 0);
        chk("wd_restart_fire", 64'(d_to), 1);
`else
        repeat (TO + 5) step(0, 0, 0, 0);
        chk("nowd_done", 64'(d_done), 0);
        chk("nowd_timeout", 64'(d_to), 0);
`endif

        // Randomized segments with varying tick density and occasional resets.
        for (int seg = 0; seg < 30; seg++) begin
            pv = $urandom_range(0, 100);
            step(1, 0, 0, 0);
            for (int n = 0; n < 150; n++) begin
                rv = ($urandom_range(0, 99) < pv);
                rc = ($urandom_range(0, 1) == 1) ? 32'd0 : 32'($urandom);
                step(($urandom_range(0, 299) == 0), rv, ($urandom_range(0, 49) == 0), rc);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
